// File: rtl/instr_fetch.sv
// Instruction fetch unit: three-state fetch/issue loop with branch redirect,
// downstream stall and a saturating count of consumed instructions.
module instr_fetch (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        run_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [7:0]  branch_offset_i,
  output logic        mem_req_o,
  output logic [7:0]  mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  instr_o,
  output logic [1:0]  op_o,
  output logic        instr_valid_o,
  output logic [7:0]  pc_next_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  pc_next_q, pc_next_d;
  logic [15:0] count_q, count_d;

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q   <= StIdle;
      pc_q      <= 8'h00;
      instr_q   <= 8'h00;
      pc_next_q <= 8'h00;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    count_d   = count_q;
    unique case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        // A branch outranks a coincident ack: the returned word is discarded.
        if (branch_taken_i) begin
          pc_d    = pc_next_q + branch_offset_i;
          state_d = StFetch;
        end else if (mem_ack_i) begin
          instr_d   = mem_data_i;
          pc_d      = pc_q + 8'd1;
          pc_next_d = pc_q + 8'd1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (branch_taken_i) begin
          pc_d    = pc_next_q + branch_offset_i;
          state_d = StFetch;
        end else if (!stall_i) begin
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = run_i ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_req_o     = (state_q == StFetch);
  assign mem_addr_o    = pc_q;
  assign instr_valid_o = (state_q == StIssue);
  assign instr_o       = instr_q;
  assign op_o          = instr_q[7:6];
  assign pc_next_o     = pc_next_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level model of the
// fetch/issue sequence (expected address, issued word, PC+1 and count).
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [7:0]  off = 8'h00;
  logic        ack = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [7:0]  instr;
  logic [1:0]  op;
  logic        valid;
  logic [7:0]  pc_next;
  logic [15:0] count;

  instr_fetch dut (
    .clk_i          (clk),
    .clear_i        (clear),
    .run_i          (run),
    .stall_i        (stall),
    .branch_taken_i (br),
    .branch_offset_i(off),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_ack_i      (ack),
    .mem_data_i     (data),
    .instr_o        (instr),
    .op_o           (op),
    .instr_valid_o  (valid),
    .pc_next_o      (pc_next),
    .instr_count_o  (count)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  int          vecs = 0;
  int          errs = 0;
  logic [7:0]  m_pc, m_pcnext, m_instr;
  logic [15:0] m_count;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_unit();
    clear = 1'b1; run = 1'b0; stall = 1'b0; br = 1'b0; ack = 1'b0;
    tick();
    clear = 1'b0; run = 1'b1;
    m_pc = 8'h00; m_pcnext = 8'h00; m_instr = 8'h00; m_count = 16'h0000;
    tick();
  endtask

  // Wait lat cycles without ack, then ack with mem[pc]; ends with the word issued.
  task automatic fetch_issue(input int lat);
    for (int i = 0; i < lat; i++) begin
      vecs++;
      if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
        errs++;
        $display("FAIL fetch_hold: req=%b addr=%h, expected req=1 addr=%h", mem_req, mem_addr, m_pc);
      end
      tick();
    end
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== m_pc || valid !== 1'b0) begin
      errs++;
      $display("FAIL fetch_req: req=%b addr=%h valid=%b, expected 1 %h 0", mem_req, mem_addr, valid,
               m_pc);
    end
    ack = 1'b1; data = mem[m_pc];
    tick();
    ack = 1'b0; data = 8'($urandom);
    m_instr = mem[m_pc]; m_pc = m_pc + 8'd1; m_pcnext = m_pc;
    vecs++;
    if ({valid, mem_req, instr, op, pc_next} !== {1'b1, 1'b0, m_instr, m_instr[7:6], m_pcnext}) begin
      errs++;
      $display("FAIL issue: valid=%b req=%b instr=%h op=%b pcn=%h, expected 1 0 %h %b %h", valid,
               mem_req, instr, op, pc_next, m_instr, m_instr[7:6], m_pcnext);
    end
  endtask

  task automatic consume(input int stalls, input bit run_after);
    stall = 1'b1;
    for (int i = 0; i < stalls; i++) begin
      tick();
      vecs++;
      if ({valid, mem_req, instr, pc_next, count} !== {1'b1, 1'b0, m_instr, m_pcnext, m_count}) begin
        errs++;
        $display("FAIL stall_hold: valid=%b req=%b instr=%h pcn=%h cnt=%h, expected 1 0 %h %h %h",
                 valid, mem_req, instr, pc_next, count, m_instr, m_pcnext, m_count);
      end
    end
    stall = 1'b0; run = run_after;
    tick();
    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    vecs++;
    if (count !== m_count || valid !== 1'b0 || mem_req !== run_after ||
        (run_after && mem_addr !== m_pc)) begin
      errs++;
      $display("FAIL consume: cnt=%h valid=%b req=%b addr=%h, expected %h 0 %b %h", count, valid,
               mem_req, mem_addr, m_count, run_after, m_pc);
    end
  endtask

  task automatic idle_restart();
    br = 1'b1; off = 8'($urandom);
    tick();
    br = 1'b0;
    vecs++;
    if (mem_req !== 1'b0 || valid !== 1'b0 || mem_addr !== m_pc) begin
      errs++;
      $display("FAIL idle_branch: req=%b valid=%b addr=%h, expected 0 0 %h", mem_req, valid,
               mem_addr, m_pc);
    end
    run = 1'b1;
    tick();
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
      errs++;
      $display("FAIL restart: req=%b addr=%h, expected 1 %h", mem_req, mem_addr, m_pc);
    end
  endtask

  task automatic branch_issue(input logic [7:0] o, input bit with_stall);
    br = 1'b1; off = o; stall = with_stall;
    tick();
    br = 1'b0; stall = 1'b0;
    m_pc = m_pcnext + o;
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== m_pc || valid !== 1'b0 || count !== m_count) begin
      errs++;
      $display("FAIL branch_issue: req=%b addr=%h valid=%b cnt=%h, expected 1 %h 0 %h", mem_req,
               mem_addr, valid, count, m_pc, m_count);
    end
  endtask

  task automatic branch_fetch(input logic [7:0] o, input bit with_ack);
    br = 1'b1; off = o; ack = with_ack; data = ~mem[m_pc];
    tick();
    br = 1'b0; ack = 1'b0;
    m_pc = m_pcnext + o;
    vecs++;
    if ({mem_req, mem_addr, valid, instr, pc_next} !== {1'b1, m_pc, 1'b0, m_instr, m_pcnext}) begin
      errs++;
      $display("FAIL branch_fetch: req=%b addr=%h valid=%b instr=%h pcn=%h, expected 1 %h 0 %h %h",
               mem_req, mem_addr, valid, instr, pc_next, m_pc, m_instr, m_pcnext);
    end
  endtask

  task automatic check_zero(input string name);
    vecs++;
    if ({mem_req, mem_addr, instr, op, valid, pc_next, count} !== 44'h0) begin
      errs++;
      $display("FAIL %s: req=%b addr=%h instr=%h op=%b valid=%b pcn=%h cnt=%h, expected all 0",
               name, mem_req, mem_addr, instr, op, valid, pc_next, count);
    end
  endtask

  task automatic test_reset();
    #1;
    check_zero("reset");
    reset_unit();
    vecs++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errs++;
      $display("FAIL first_addr: req=%b addr=%h, expected 1 00", mem_req, mem_addr);
    end
  endtask

  task automatic test_first_fetch();
    fetch_issue(0);
    vecs++;
    if (instr !== 8'h4D || op !== 2'b01 || pc_next !== 8'h01) begin
      errs++;
      $display("FAIL first_instr: instr=%h op=%b pcn=%h, expected 4d 01 01", instr, op, pc_next);
    end
    consume(0, 1'b1);
  endtask

  task automatic test_latency();
    fetch_issue(2);
    consume(0, 1'b1);
  endtask

  task automatic test_stall();
    fetch_issue(1);
    consume(4, 1'b1);
  endtask

  task automatic test_branch();
    reset_unit();
    for (int i = 0; i < 4; i++) begin
      fetch_issue(0);
      consume(0, 1'b1);
    end
    fetch_issue(0);
    branch_issue(8'hFD, 1'b0);
    vecs++;
    if (mem_addr !== 8'h02 || count !== 16'd4) begin
      errs++;
      $display("FAIL branch_target: addr=%h cnt=%0d, expected 02 4", mem_addr, count);
    end
    branch_fetch(8'h10, 1'b1);
    fetch_issue(1);
    consume(0, 1'b1);
    fetch_issue(0);
    branch_issue(8'h22, 1'b1);
    fetch_issue(0);
    consume(1, 1'b1);
  endtask

  task automatic test_wrap();
    fetch_issue(0);
    branch_issue(8'hFF - m_pcnext, 1'b0);
    fetch_issue(0);
    vecs++;
    if (pc_next !== 8'h00) begin
      errs++;
      $display("FAIL wrap: pcn=%h, expected 00", pc_next);
    end
    consume(0, 1'b1);
  endtask

  task automatic test_saturate();
    fetch_issue(0);
    consume(0, 1'b0);
    force dut.count_q = 16'hFFFD;
    tick();
    release dut.count_q;
    m_count = 16'hFFFD;
    vecs++;
    if (count !== 16'hFFFD) begin
      errs++;
      $display("FAIL preset: cnt=%h, expected fffd", count);
    end
    run = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch_issue(0);
      consume(0, 1'b1);
    end
  endtask

  task automatic test_clear();
    fetch_issue(0);
    consume(0, 1'b1);
    tick();
    clear = 1'b1;
    #1;
    check_zero("clear_fetch");
    tick();
    clear = 1'b0; run = 1'b0; ack = 1'b1; data = 8'hC3;
    tick();
    ack = 1'b0;
    check_zero("late_ack");
    m_pc = 8'h00; m_pcnext = 8'h00; m_instr = 8'h00; m_count = 16'h0000;
    run = 1'b1;
    tick();
    fetch_issue(0);
    stall = 1'b1;
    tick();
    clear = 1'b1;
    #1;
    check_zero("clear_stall");
    tick();
    stall = 1'b0;
    reset_unit();
    fetch_issue(0);
    consume(0, 1'b1);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) branch_fetch(8'($urandom), 1'($urandom));
      fetch_issue($urandom_range(0, 3));
      r = $urandom_range(0, 5);
      if (r == 0) begin
        branch_issue(8'($urandom), 1'($urandom));
      end else if (r == 1) begin
        consume($urandom_range(0, 2), 1'b0);
        idle_restart();
      end else begin
        consume($urandom_range(0, 2), 1'b1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h4D;
    m_pc = 8'h00; m_pcnext = 8'h00; m_instr = 8'h00; m_count = 16'h0000;
    test_reset();
    test_first_fetch();
    test_latency();
    test_stall();
    test_branch();
    test_wrap();
    test_saturate();
    test_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have ports as follows; clock and reset are listed first.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Clear  input  1  reset, asynchronous and active-high.
REQ-004 Run  input  1  fetch enable; 0 parks the unit in IDLE after the current instruction is consumed.
REQ-005 Stall  input  1  downstream hold; 1 freezes the issued instruction.
REQ-006 BranchTaken  input  1  one-cycle pulse from datapath; redirect PC.
REQ-007 BranchOffset  input  8  two's-complement offset, added to PCNext.
REQ-008 MemReq  output  1  instruction-memory read request.
REQ-009 MemAddr  output  8  instruction-memory address.
REQ-010 MemAck  input  1  memory returns MemData this cycle; latency 1..N cycles.
REQ-011 MemData  input  8  instruction word {op[7:6], rs[5:4], rt[3:2], rd/imm[1:0]}.
REQ-012 Instr  output  8  registered issued instruction.
REQ-013 Op  output  2  Instr[7:6]; feeds the control unit opcode input.
REQ-014 InstrValid  output  1  Instr holds a valid, unconsumed instruction.
REQ-015 PCNext  output  8  address of issued instruction + 1, mod 256.
REQ-016 InstrCount  output  16  number of instructions consumed, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, ISSUE; PC is an 8-bit register.
REQ-018 IDLE: MemReq=0, InstrValid=0; Run=1 -> FETCH next cycle.
REQ-019 FETCH: MemReq=1, MemAddr=PC; MemAck=1 -> Instr<=MemData, PCNext<=PC+1, PC<=PC+1, go ISSUE.
REQ-020 FETCH without MemAck: hold MemReq and MemAddr stable, no timeout.
REQ-021 ISSUE: InstrValid=1, MemReq=0; the instruction is consumed on the first cycle with Stall=0.
REQ-022 On consume: InstrCount+1 (saturating at 16'hFFFF); Run=1 -> FETCH, Run=0 -> IDLE.
REQ-023 ISSUE with Stall=1: Instr, Op, PCNext, InstrValid held unchanged; no count.
REQ-024 Fetch-to-issue latency: InstrValid rises the cycle after MemAck is sampled.
REQ-025 BranchTaken=1 in FETCH or ISSUE: PC<=PCNext+BranchOffset (8-bit wrap); the current Instr is dropped (InstrValid<=0); state<=FETCH; count not incremented.
REQ-026 BranchTaken=1 together with MemAck in FETCH: MemData is discarded and the refetch starts at the target next cycle.
REQ-027 BranchTaken=1 together with Stall=1 in ISSUE: the branch wins and the held instruction is dropped.
REQ-028 BranchTaken in IDLE is ignored.
REQ-029 PC and PCNext wrap 8'hFF -> 8'h00 with no flag.
REQ-030 Run deasserted during FETCH: the outstanding request completes and issues, then the unit goes to IDLE after consume.
REQ-031 Op is combinationally equal to Instr[7:6] at all times.

Reset
REQ-032 Clear=1 SHALL immediately and asynchronously force: state=IDLE, PC=0, Instr=0, Op=0, InstrValid=0, MemReq=0, MemAddr=0, PCNext=0, InstrCount=0.
REQ-033 Clear mid-FETCH SHALL abandon the request; a late MemAck after release is ignored unless the unit is in FETCH.
REQ-034 After Clear falls, the first fetch SHALL be from address 0.

Verification
REQ-035 Reset then Run=1, memory 1-cycle ack, mem[0]=8'h4D -> MemAddr=0, next cycle Instr=8'h4D, Op=2'b01, PCNext=1, InstrValid=1.
REQ-036 3-cycle ack latency -> MemReq and MemAddr stable for 3 cycles, InstrValid rises exactly 1 cycle after ack.
REQ-037 Stall=1 for 4 cycles in ISSUE -> Instr unchanged, InstrCount unchanged, no MemReq; release -> count+1, next fetch at PCNext.
REQ-038 Branch at PCNext=8'h05 with offset 8'hFD -> next MemAddr=8'h02, dropped instruction not counted; repeat with BranchTaken coincident with MemAck -> data discarded, refetch at target.
REQ-039 PC=8'hFF fetch -> PCNext=8'h00, next MemAddr=8'h00; InstrCount preset near 16'hFFFF -> holds at 16'hFFFF.
REQ-040 Clear asserted mid-FETCH and mid-Stall -> all outputs 0 the same cycle, restart fetch from 0.
